cpu_step_seq: RTL and testbench

//  Parametrised instruction-phase sequencer for the cpu core; successor to the fixed 4-step clk_gen.

---
 rtl/cpu_step_seq_pkg.sv | 17 +
 rtl/cpu_retire_cnt.sv | 32 +++
 rtl/cpu_step_seq.sv | 148 ++++++++++++++
 tb/tb_cpu_step_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_seq_pkg.sv
// ---------------------------------------------------------------------------
// cpu_step_seq_pkg
//   Shared definitions for the instruction-phase sequencer and its helpers.
//   - state_t      : sequencer state encoding (IDLE / RUN / HALTED)
//   - DEF_NSTEPS   : default number of phases per instruction
// ---------------------------------------------------------------------------
package cpu_step_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int DEF_NSTEPS = 4;

endpackage

// File: rtl/cpu_retire_cnt.sv
// ---------------------------------------------------------------------------
// cpu_retire_cnt
//   Free-running wrap counter with increment enable. Also used for write-back
//   statistics, so it carries no sequencer-specific logic.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low clear
//     i_inc  in   increment by one on the next rising edge
//     o_cnt  out  current count, wraps modulo 2**CNT_W
// ---------------------------------------------------------------------------
module cpu_retire_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_step_seq.sv
// ---------------------------------------------------------------------------
// cpu_step_seq
//   Instruction-phase sequencer. Emits one-hot phase strobes to the datapath
//   stages, with free-run / single-step modes, stall, flush and halt control,
//   and a retired-instruction counter.
//   Ports:
//     clk         in   rising-edge clock
//     rst_n       in   asynchronous active-low reset
//     run_i       in   free-run: start next instruction back-to-back
//     step_req_i  in   one-cycle pulse: run a single instruction from IDLE
//     stall_i     in   hold the current phase
//     flush_i     in   abort current instruction, restart at phase 0
//     halt_i      in   halt once the current instruction completes
//     step_o      out  one-hot phase strobe, zero outside RUN
//     phase_o     out  binary index of the active phase, zero outside RUN
//     busy_o      out  high while in RUN
//     done_o      out  one-cycle pulse when an instruction retires
//     retired_o   out  retired instruction count (wraps)
//     halted_o    out  high while HALTED
//   Control handshake: inputs are plain levels sampled on every rising edge;
//   there is no ready/ack. A step_req_i pulse that arrives outside IDLE is
//   dropped, not queued.
// ---------------------------------------------------------------------------
module cpu_step_seq
    import cpu_step_seq_pkg::*;
#(
    parameter  int NSTEPS = DEF_NSTEPS,
    parameter  int CNT_W  = 32,
    localparam int PH_W   = (NSTEPS > 1) ? $clog2(NSTEPS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic              step_req_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              halt_i,
    output logic [NSTEPS-1:0] step_o,
    output logic [PH_W-1:0]   phase_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  retired_o,
    output logic              halted_o
);

    localparam logic [PH_W-1:0]   LAST_PH = PH_W'(NSTEPS - 1);
    localparam logic [NSTEPS-1:0] STEP0   = NSTEPS'(1);

    state_t             r_state;
    logic [PH_W-1:0]    r_phase;
    logic [NSTEPS-1:0]  r_step;
    logic               r_done;
    logic               r_halt_pend;
    logic               w_retire;

    // An instruction retires when the last phase advances unobstructed.
    assign w_retire = (r_state == ST_RUN) && !flush_i && !stall_i && (r_phase == LAST_PH);

    // FSM, phase register and one-hot strobe all update together so step_o
    // and phase_o can never disagree. Every path leaving RUN returns phase to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_step      <= '0;
            r_done      <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (halt_i) begin
                        r_state <= ST_HALT;
                    end else if (run_i || step_req_i) begin
                        r_state <= ST_RUN;
                        r_phase <= '0;
                        r_step  <= STEP0;
                    end
                end

                ST_RUN: begin
                    // A halt request is remembered until the instruction ends,
                    // even across stalls and flushes.
                    if (halt_i) begin
                        r_halt_pend <= 1'b1;
                    end
                    if (flush_i) begin
                        r_phase <= '0;
                        if (run_i) begin
                            r_step <= STEP0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_step  <= '0;
                        end
                    end else if (stall_i) begin
                        // hold everything
                    end else if (r_phase != LAST_PH) begin
                        r_phase <= r_phase + PH_W'(1);
                        r_step  <= {r_step[NSTEPS-2:0], 1'b0};
                    end else begin
                        r_done  <= 1'b1;
                        r_phase <= '0;
                        if (r_halt_pend || halt_i) begin
                            r_state     <= ST_HALT;
                            r_step      <= '0;
                            r_halt_pend <= 1'b0;
                        end else if (run_i) begin
                            r_step <= STEP0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_step  <= '0;
                        end
                    end
                end

                ST_HALT: begin
                    // Only reset leaves HALTED.
                    r_phase     <= '0;
                    r_step      <= '0;
                    r_halt_pend <= 1'b0;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_phase     <= '0;
                    r_step      <= '0;
                    r_halt_pend <= 1'b0;
                end
            endcase
        end
    end

    cpu_retire_cnt #(
        .CNT_W (CNT_W)
    ) u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_retire),
        .o_cnt (retired_o)
    );

    assign step_o   = r_step;
    assign phase_o  = r_phase;
    assign busy_o   = (r_state == ST_RUN);
    assign halted_o = (r_state == ST_HALT);
    assign done_o   = r_done;

endmodule

// File: tb/tb_cpu_step_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_seq
//   Directed bench for cpu_step_seq with NSTEPS=4, CNT_W=8. Inputs change
//   1 time unit after the rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_cpu_step_seq;

    logic       clk;
    logic       rst_n;
    logic       run_i;
    logic       step_req_i;
    logic       stall_i;
    logic       flush_i;
    logic       halt_i;
    logic [3:0] step_o;
    logic [1:0] phase_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] retired_o;
    logic       halted_o;

    int n_checks;
    int n_fail;
    int done_cnt;

    cpu_step_seq #(
        .NSTEPS (4),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run_i),
        .step_req_i (step_req_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .halt_i     (halt_i),
        .step_o     (step_o),
        .phase_o    (phase_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .retired_o  (retired_o),
        .halted_o   (halted_o)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outs(input string tag);
        check_eq({tag, "_step"},    32'(step_o),    32'h0);
        check_eq({tag, "_phase"},   32'(phase_o),   32'h0);
        check_eq({tag, "_busy"},    32'(busy_o),    32'h0);
        check_eq({tag, "_done"},    32'(done_o),    32'h0);
        check_eq({tag, "_retired"}, 32'(retired_o), 32'h0);
        check_eq({tag, "_halted"},  32'(halted_o),  32'h0);
    endtask

    task automatic do_reset();
        run_i      = 1'b0;
        step_req_i = 1'b0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        halt_i     = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_idle_outs("rst");
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;

        // 1: free-run 3 instructions
        do_reset();
        run_i    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq("t1_step", 32'(step_o), 32'(4'b0001 << (k % 4)));
            check_eq("t1_phase", 32'(phase_o), 32'(k % 4));
            done_cnt += int'(done_o);
            if (k == 11) run_i = 1'b0;
        end
        check_eq("t1_retired_mid", 32'(retired_o), 32'd2);
        tick();
        done_cnt += int'(done_o);
        check_eq("t1_done_cnt", 32'(done_cnt), 32'd3);
        check_eq("t1_retired", 32'(retired_o), 32'd3);
        check_eq("t1_idle_step", 32'(step_o), 32'h0);
        check_eq("t1_idle_busy", 32'(busy_o), 32'h0);

        // 2: stall two cycles in phase 2
        do_reset();
        run_i = 1'b1;
        tick(); check_eq("t2_p0", 32'(step_o), 32'h1);
        tick(); check_eq("t2_p1", 32'(step_o), 32'h2);
        tick(); check_eq("t2_p2", 32'(step_o), 32'h4);
        stall_i = 1'b1;
        tick(); check_eq("t2_hold1", 32'(step_o), 32'h4);
        check_eq("t2_hold1_done", 32'(done_o), 32'h0);
        tick(); check_eq("t2_hold2", 32'(step_o), 32'h4);
        stall_i = 1'b0;
        tick(); check_eq("t2_p3", 32'(step_o), 32'h8);
        check_eq("t2_p3_done", 32'(done_o), 32'h0);
        run_i = 1'b0;
        tick(); check_eq("t2_done", 32'(done_o), 32'h1);
        check_eq("t2_retired", 32'(retired_o), 32'd1);
        check_eq("t2_step_end", 32'(step_o), 32'h0);

        // 3: single step, second request mid-instruction is dropped
        do_reset();
        step_req_i = 1'b1;
        tick(); step_req_i = 1'b0;
        check_eq("t3_p0", 32'(step_o), 32'h1);
        tick(); check_eq("t3_p1", 32'(step_o), 32'h2);
        step_req_i = 1'b1;
        tick(); step_req_i = 1'b0;
        check_eq("t3_p2", 32'(step_o), 32'h4);
        tick(); check_eq("t3_p3", 32'(step_o), 32'h8);
        tick(); check_eq("t3_done", 32'(done_o), 32'h1);
        check_eq("t3_step_idle", 32'(step_o), 32'h0);
        check_eq("t3_busy", 32'(busy_o), 32'h0);
        check_eq("t3_retired", 32'(retired_o), 32'd1);
        tick(); check_eq("t3_done_pulse", 32'(done_o), 32'h0);
        check_eq("t3_still_idle", 32'(step_o), 32'h0);
        check_eq("t3_retired2", 32'(retired_o), 32'd1);

        // 4: flush beats stall in phase 3; flush without run_i goes idle
        do_reset();
        run_i = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check_eq("t4_p3", 32'(step_o), 32'h8);
        flush_i = 1'b1;
        stall_i = 1'b1;
        tick(); flush_i = 1'b0; stall_i = 1'b0;
        check_eq("t4_flush_step", 32'(step_o), 32'h1);
        check_eq("t4_flush_done", 32'(done_o), 32'h0);
        check_eq("t4_flush_ret", 32'(retired_o), 32'd0);
        check_eq("t4_flush_busy", 32'(busy_o), 32'h1);
        tick(); check_eq("t4_p1", 32'(step_o), 32'h2);
        run_i   = 1'b0;
        flush_i = 1'b1;
        tick(); flush_i = 1'b0;
        check_eq("t4_fl_idle_step", 32'(step_o), 32'h0);
        check_eq("t4_fl_idle_busy", 32'(busy_o), 32'h0);
        check_eq("t4_fl_idle_done", 32'(done_o), 32'h0);

        // 5: halt pulse in phase 1, instruction completes, then HALTED
        do_reset();
        run_i = 1'b1;
        tick(); tick();
        check_eq("t5_p1", 32'(step_o), 32'h2);
        halt_i = 1'b1;
        tick(); halt_i = 1'b0;
        check_eq("t5_p2", 32'(step_o), 32'h4);
        tick(); check_eq("t5_p3", 32'(step_o), 32'h8);
        check_eq("t5_p3_halted", 32'(halted_o), 32'h0);
        tick();
        check_eq("t5_done", 32'(done_o), 32'h1);
        check_eq("t5_retired", 32'(retired_o), 32'd1);
        check_eq("t5_halted", 32'(halted_o), 32'h1);
        check_eq("t5_step", 32'(step_o), 32'h0);
        check_eq("t5_busy", 32'(busy_o), 32'h0);
        step_req_i = 1'b1;
        tick(); step_req_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_eq("t5_stay_halted", 32'(halted_o), 32'h1);
        check_eq("t5_stay_step", 32'(step_o), 32'h0);
        check_eq("t5_stay_ret", 32'(retired_o), 32'd1);
        check_eq("t5_stay_done", 32'(done_o), 32'h0);

        // 5b: halt from IDLE takes priority over run
        do_reset();
        halt_i = 1'b1;
        run_i  = 1'b1;
        tick(); halt_i = 1'b0;
        check_eq("t5b_halted", 32'(halted_o), 32'h1);
        check_eq("t5b_busy", 32'(busy_o), 32'h0);

        // 6: counter wrap, then async reset mid-instruction
        do_reset();
        run_i = 1'b1;
        for (int t = 1; t <= 1021; t++) tick();
        check_eq("t6_ret255", 32'(retired_o), 32'd255);
        check_eq("t6_done255", 32'(done_o), 32'h1);
        for (int t = 0; t < 4; t++) tick();
        check_eq("t6_wrap", 32'(retired_o), 32'd0);
        check_eq("t6_wrap_done", 32'(done_o), 32'h1);
        for (int t = 0; t < 4; t++) tick();
        check_eq("t6_after_wrap", 32'(retired_o), 32'd1);
        tick(); tick();
        check_eq("t6_p2", 32'(step_o), 32'h4);
        check_eq("t6_p2_phase", 32'(phase_o), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outs("t6_async");
        run_i = 1'b0;
        tick();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
